// File: rtl/gs_pkg.sv
// Shared types for the gs core front end: fetch-stage FSM states and buffer entries.
package gs_pkg;

    localparam int GS_ADDR_W = 32;
    localparam int GS_WORD_W = 32;

    typedef enum logic [1:0] {
        IF_IDLE,
        IF_RUN,
        IF_DRAIN
    } if_state_e;

    typedef struct packed {
        logic [GS_ADDR_W-1:0] pc;
        logic [GS_WORD_W-1:0] instr;
    } if_entry_t;

endpackage

// File: rtl/gs_if_prefetch_if.sv
// Instruction memory port: req/gnt address phase, rvalid/rdata response phase.
interface gs_if_prefetch_if #(
    parameter int ADDR_SIZE = 32,
    parameter int WORD_SIZE = 32
);
    logic                 req;
    logic [ADDR_SIZE-1:0] addr;
    logic                 gnt;
    logic                 rvalid;
    logic [WORD_SIZE-1:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/gs_fetch_fifo.sv
// Small power-of-two FIFO with flush; head is read combinationally.
module gs_fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    // A push into a full FIFO is only accepted when the head leaves the same cycle.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr] <= wdata;
    end
endmodule

// File: rtl/gs_if_prefetch.sv
// Prefetching instruction fetch stage: pipelined memory requests, PC-tagged buffer,
// flush and stale-response discard on redirect.
module gs_if_prefetch
    import gs_pkg::*;
#(
    parameter int                   ADDR_SIZE  = 32,
    parameter int                   WORD_SIZE  = 32,
    parameter logic [ADDR_SIZE-1:0] BOOT_ADDR  = '0,
    parameter int                   FIFO_DEPTH = 4,
    localparam int                  CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  boot_i,
    input  logic                  redirect_i,
    input  logic [ADDR_SIZE-1:0]  redirect_addr_i,
    input  logic                  halt_if_i,
    gs_if_prefetch_if.master      imem,
    output logic                  if_valid_o,
    input  logic                  id_ready_i,
    output logic [WORD_SIZE-1:0]  instr_data_o,
    output logic [ADDR_SIZE-1:0]  pc_out_o,
    output logic [ADDR_SIZE-1:0]  pc_out_4_o,
    output logic [CW-1:0]         fifo_count_o
);
    typedef struct packed {
        logic [ADDR_SIZE-1:0] pc;
        logic [WORD_SIZE-1:0] instr;
    } entry_t;

    if_state_e            state;
    logic [ADDR_SIZE-1:0] fetch_pc, ret_pc;
    logic [CW-1:0]        outst, outst_nxt, disc;
    logic                 pend, redir, gnt_acc, credit, ibuf_push, ibuf_pop, ibuf_empty;
    entry_t               wentry, head;
    logic                 unused_ibuf_full, unused_pcq_full, unused_pcq_empty;
    logic [CW-1:0]        unused_pcq_count;

    // boot_i outside IDLE behaves exactly like a redirect to BOOT_ADDR.
    assign redir     = (redirect_i | boot_i) & (state != IF_IDLE);
    assign gnt_acc   = imem.req & imem.gnt;
    assign outst_nxt = outst + CW'(gnt_acc) - CW'(imem.rvalid);
    assign credit    = ((CW+1)'(fifo_count_o) + (CW+1)'(outst)) < (CW+1)'(FIFO_DEPTH);

    // An ungranted request stays up (same address) until granted; only a redirect drops it.
    assign imem.req  = (state == IF_RUN) & ~redir & (pend | (~halt_if_i & credit));
    assign imem.addr = fetch_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IF_IDLE;
            fetch_pc <= '0;
            outst    <= '0;
            disc     <= '0;
            pend     <= 1'b0;
        end else begin
            outst <= outst_nxt;
            pend  <= imem.req & ~imem.gnt;
            if (gnt_acc) fetch_pc <= fetch_pc + ADDR_SIZE'(4);
            if (state == IF_IDLE) begin
                if (boot_i) begin
                    state    <= IF_RUN;
                    fetch_pc <= BOOT_ADDR;
                end
            end else begin
                if (state == IF_DRAIN && imem.rvalid) begin
                    disc <= disc - CW'(1);
                    if (disc == CW'(1)) state <= IF_RUN;
                end
                if (redir) begin
                    fetch_pc <= boot_i ? BOOT_ADDR : (redirect_addr_i & ~ADDR_SIZE'(3));
                    disc     <= outst_nxt;
                    state    <= (outst_nxt != '0) ? IF_DRAIN : IF_RUN;
                end
            end
        end
    end

    // Return-PC queue is never flushed: stale entries retire with their discarded responses.
    gs_fetch_fifo #(.WIDTH(ADDR_SIZE), .DEPTH(FIFO_DEPTH)) u_pcq (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (gnt_acc),
        .wdata (fetch_pc),
        .pop   (imem.rvalid),
        .rdata (ret_pc),
        .count (unused_pcq_count),
        .full  (unused_pcq_full),
        .empty (unused_pcq_empty)
    );

    assign wentry    = '{pc: ret_pc, instr: imem.rdata};
    assign ibuf_push = imem.rvalid & (state == IF_RUN);
    assign ibuf_pop  = if_valid_o & id_ready_i;

    gs_fetch_fifo #(.WIDTH(ADDR_SIZE + WORD_SIZE), .DEPTH(FIFO_DEPTH)) u_ibuf (
        .clk   (clk),
        .rst   (rst),
        .flush (redir),
        .push  (ibuf_push),
        .wdata (wentry),
        .pop   (ibuf_pop),
        .rdata (head),
        .count (fifo_count_o),
        .full  (unused_ibuf_full),
        .empty (ibuf_empty)
    );

    assign if_valid_o   = ~ibuf_empty & ~redir;
    assign instr_data_o = ibuf_empty ? '0 : head.instr;
    assign pc_out_o     = ibuf_empty ? '0 : head.pc;
    assign pc_out_4_o   = ibuf_empty ? '0 : head.pc + ADDR_SIZE'(4);
endmodule
